// File: rtl/spi_xfer_sequencer.sv
// TX-FIFO-fed sequencer in front of an SPI master: launches one transfer per queued
// word, captures the returned word on a valid/ready port, and aborts stalled transfers.
module spi_xfer_sequencer #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [DATA_W-1:0]        rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     spi_start,
  output logic [DATA_W-1:0]        spi_data_in,
  input  logic [DATA_W-1:0]        spi_data_out,
  input  logic                     spi_done,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Handshakes: a word moves on tx when tx_valid && tx_ready at a rising edge, and
  // on rx when rx_valid && rx_ready; a valid side holds its data until accepted.

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                spi_start_q, spi_start_d;
  logic [DATA_W-1:0]   spi_data_in_q, spi_data_in_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic push;
  logic pop;
  logic done_rise;

  assign tx_ready    = (level_q != LVL_W'(DEPTH));
  assign push        = tx_valid && tx_ready;
  assign done_rise   = spi_done && !done_q;

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign spi_start   = spi_start_q;
  assign spi_data_in = spi_data_in_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign fifo_level  = level_q;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    spi_start_d   = 1'b0;
    spi_data_in_d = spi_data_in_q;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;
    cnt_d         = cnt_q;
    done_d        = spi_done;
    pop           = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // A pending response blocks the next launch so the single rx register never overflows.
        if ((level_q != '0) && !rx_valid_q) begin
          pop           = 1'b1;
          spi_data_in_d = mem_q[rd_ptr_q];
          spi_start_d   = 1'b1;
          cnt_d         = '0;
          busy_d        = 1'b1;
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (done_rise) begin
          rx_data_d  = spi_data_out;
          rx_valid_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      spi_start_q   <= 1'b0;
      spi_data_in_q <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      spi_start_q   <= spi_start_d;
      spi_data_in_q <= spi_data_in_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

endmodule
